// File: rtl/key_round_sched.sv
`default_nettype none
// ============================================================================
//  Module      : key_round_sched
//  Description : Round-key sequencer for the AES-256 core. Walks the address
//                of the round-key ROM through one full key schedule per block
//                (NUM_ROUNDS+1 keys), registers each key and presents it to
//                the AddRoundKey stage over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1           system clock, rising edge
//    resetn       in   1           asynchronous reset, active low
//    start        in   1           start one key schedule (honoured in IDLE)
//    mode_dec     in   1           0 = ascending ROM order, 1 = descending
//    abort        in   1           terminate the current schedule
//    addr_romKey  out  ADDR_WIDTH  registered ROM address
//    key_in       in   DATA_WIDTH  ROM data, combinational from addr_romKey
//    rk_data      out  DATA_WIDTH  registered round key
//    rk_valid     out  1           rk_data valid
//    rk_ready     in   1           datapath accepts rk_data
//    rk_round     out  ADDR_WIDTH  round index of rk_data (always ascending)
//    rk_last      out  1           rk_valid for the final round key
//    busy         out  1           schedule in progress (any state but IDLE)
//    done         out  1           one-cycle pulse after the last key is taken
// ============================================================================
module key_round_sched #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_ROUNDS = 14
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  mode_dec,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] addr_romKey,
    input  logic [DATA_WIDTH-1:0] key_in,
    output logic [DATA_WIDTH-1:0] rk_data,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [ADDR_WIDTH-1:0] rk_round,
    output logic                  rk_last,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_fetch   = 2'd1;
    localparam logic [1:0] c_st_present = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    // Index of the final round key, also the first ROM address when decrypting.
    localparam logic [ADDR_WIDTH-1:0] c_last_round = ADDR_WIDTH'(NUM_ROUNDS);
    localparam logic [ADDR_WIDTH-1:0] c_one        = ADDR_WIDTH'(1);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [1:0]            state_q,      state_d;
    logic                  mode_dec_q,   mode_dec_d;
    logic [ADDR_WIDTH-1:0] round_cnt_q,  round_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] rk_data_q,    rk_data_d;
    logic                  rk_valid_q,   rk_valid_d;
    logic [ADDR_WIDTH-1:0] rk_round_q,   rk_round_d;

    logic w_launch;      // a new schedule is accepted this cycle
    logic w_handshake;   // current key taken by the datapath this cycle
    logic w_final_key;   // the key being presented is the last of the block

    assign w_launch    = (state_q == c_st_idle) && start && !abort;
    assign w_handshake = rk_valid_q && rk_ready;
    assign w_final_key = (round_cnt_q == c_last_round);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // abort wins over both the handshake and the DONE -> IDLE return, so a
    // block that is aborted on its final handshake never reports done.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            c_st_idle: begin
                if (w_launch) begin
                    state_d = c_st_fetch;
                end
            end
            c_st_fetch: begin
                state_d = abort ? c_st_idle : c_st_present;
            end
            c_st_present: begin
                if (abort) begin
                    state_d = c_st_idle;
                end else if (w_handshake) begin
                    state_d = w_final_key ? c_st_done : c_st_fetch;
                end
            end
            c_st_done: begin
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // Everything holds by default, which keeps rk_data / rk_round /
    // addr_romKey stable for as long as the datapath back-pressures.
    // ------------------------------------------------------------------
    always_comb begin
        mode_dec_d  = mode_dec_q;
        round_cnt_d = round_cnt_q;
        addr_d      = addr_q;
        rk_data_d   = rk_data_q;
        rk_valid_d  = rk_valid_q;
        rk_round_d  = rk_round_q;

        unique case (state_q)
            c_st_idle: begin
                rk_valid_d = 1'b0;
                if (w_launch) begin
                    mode_dec_d  = mode_dec;
                    round_cnt_d = '0;
                    addr_d      = mode_dec ? c_last_round : '0;
                end
            end
            c_st_fetch: begin
                // The ROM has had a full cycle to settle on addr_q, so the
                // word on key_in belongs to round_cnt_q.
                if (abort) begin
                    rk_valid_d = 1'b0;
                end else begin
                    rk_data_d  = key_in;
                    rk_round_d = round_cnt_q;
                    rk_valid_d = 1'b1;
                end
            end
            c_st_present: begin
                if (abort) begin
                    rk_valid_d = 1'b0;
                end else if (w_handshake) begin
                    rk_valid_d = 1'b0;
                    // The address is left on the final key rather than
                    // stepped, so it never leaves 0..NUM_ROUNDS.
                    if (!w_final_key) begin
                        round_cnt_d = round_cnt_q + c_one;
                        addr_d      = mode_dec_q ? (addr_q - c_one)
                                                 : (addr_q + c_one);
                    end
                end
            end
            c_st_done: begin
                rk_valid_d = 1'b0;
            end
            default: begin
                rk_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_dec_q  <= 1'b0;
            round_cnt_q <= '0;
            addr_q      <= '0;
            rk_data_q   <= '0;
            rk_valid_q  <= 1'b0;
            rk_round_q  <= '0;
        end else begin
            mode_dec_q  <= mode_dec_d;
            round_cnt_q <= round_cnt_d;
            addr_q      <= addr_d;
            rk_data_q   <= rk_data_d;
            rk_valid_q  <= rk_valid_d;
            rk_round_q  <= rk_round_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != c_st_idle);
        done        = (state_q == c_st_done);
        addr_romKey = addr_q;
        rk_data     = rk_data_q;
        rk_valid    = rk_valid_q;
        rk_round    = rk_round_q;
        rk_last     = rk_valid_q && (rk_round_q == c_last_round);
    end

endmodule
`default_nettype wire
